// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game-state engine: cursor movement, piece placement, win/draw detection.
// Optional per-turn idle forfeit is compiled in with `define MOVE_TIMEOUT_EN.
module ttt_board_ctrl #(
  parameter int TIMEOUT_CYCLES = 150_000_000,
  parameter int START_CURSOR   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [17:0] grid_data,
  output logic [3:0]  cursor_pos,
  output logic        turn,
  output logic [1:0]  game_state,
  output logic [8:0]  win_mask,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] GS_PLAY  = 2'b00;
  localparam logic [1:0] GS_X_WIN = 2'b01;
  localparam logic [1:0] GS_O_WIN = 2'b10;
  localparam logic [1:0] GS_DRAW  = 2'b11;
  localparam logic [3:0] START_POS = 4'(START_CURSOR);

  state_t      state_q, state_d;
  logic [17:0] grid_q, grid_d;
  logic [3:0]  cursor_q, cursor_d;
  logic        turn_q, turn_d;
  logic [1:0]  game_state_q, game_state_d;
  logic [8:0]  win_mask_q, win_mask_d;

  logic [1:0]  mover_code;
  logic [8:0]  mine;
  logic [8:0]  occupied;
  logic        cursor_empty;
  logic        line_found;
  logic [8:0]  found_mask;

  // Column of a cell, used to stop left/right from crossing row boundaries.
  function automatic logic [1:0] col_of(input logic [3:0] c);
    case (c)
      4'd0, 4'd3, 4'd6: col_of = 2'd0;
      4'd1, 4'd4, 4'd7: col_of = 2'd1;
      default:          col_of = 2'd2;
    endcase
  endfunction

  // Lines in priority order: rows 0-2, columns 0-2, main diagonal, anti-diagonal.
  function automatic logic [8:0] line_mask(input int k);
    case (k)
      0:       line_mask = 9'b000_000_111;
      1:       line_mask = 9'b000_111_000;
      2:       line_mask = 9'b111_000_000;
      3:       line_mask = 9'b001_001_001;
      4:       line_mask = 9'b010_010_010;
      5:       line_mask = 9'b100_100_100;
      6:       line_mask = 9'b100_010_001;
      default: line_mask = 9'b001_010_100;
    endcase
  endfunction

  always_comb begin
    mover_code   = turn_q ? 2'b10 : 2'b01;
    mine         = '0;
    occupied     = '0;
    cursor_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mine[i]     = (grid_q[2*i +: 2] == mover_code);
      occupied[i] = |grid_q[2*i +: 2];
      if (cursor_q == 4'(i)) cursor_empty = ~(|grid_q[2*i +: 2]);
    end
  end

  always_comb begin
    line_found = 1'b0;
    found_mask = '0;
    for (int k = 0; k < 8; k++) begin
      if (!line_found && ((mine & line_mask(k)) == line_mask(k))) begin
        line_found = 1'b1;
        found_mask = line_mask(k);
      end
    end
  end

`ifdef MOVE_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        action_accepted;

  // A center on an occupied cell is dropped, so it does not restart the idle count.
  assign action_accepted = btn_center ? cursor_empty
                                      : (btn_up | btn_down | btn_left | btn_right);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d      = state_q;
    grid_d       = grid_q;
    cursor_d     = cursor_q;
    turn_d       = turn_q;
    game_state_d = game_state_q;
    win_mask_d   = win_mask_q;
`ifdef MOVE_TIMEOUT_EN
    idle_d       = '0;
`endif

    case (state_q)
      S_PLAY: begin
        if (btn_center) begin
          if (cursor_empty) begin
            for (int i = 0; i < 9; i++) begin
              if (cursor_q == 4'(i)) grid_d[2*i +: 2] = mover_code;
            end
            state_d = S_CHECK;
          end
        end else if (btn_up) begin
          if (cursor_q >= 4'd3) cursor_d = cursor_q - 4'd3;
        end else if (btn_down) begin
          if (cursor_q <= 4'd5) cursor_d = cursor_q + 4'd3;
        end else if (btn_left) begin
          if (col_of(cursor_q) != 2'd0) cursor_d = cursor_q - 4'd1;
        end else if (btn_right) begin
          if (col_of(cursor_q) != 2'd2) cursor_d = cursor_q + 4'd1;
        end
`ifdef MOVE_TIMEOUT_EN
        if (action_accepted) begin
          idle_d = '0;
        end else if (idle_q == 32'(TIMEOUT_CYCLES - 1)) begin
          turn_d = ~turn_q;
          idle_d = '0;
        end else begin
          idle_d = idle_q + 32'd1;
        end
`endif
      end

      S_CHECK: begin
        if (line_found) begin
          game_state_d = turn_q ? GS_O_WIN : GS_X_WIN;
          win_mask_d   = found_mask;
          state_d      = S_DONE;
        end else if (&occupied) begin
          game_state_d = GS_DRAW;
          win_mask_d   = '0;
          state_d      = S_DONE;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_PLAY;
        end
      end

      S_DONE: begin
        if (btn_center) begin
          grid_d       = '0;
          win_mask_d   = '0;
          turn_d       = 1'b0;
          cursor_d     = START_POS;
          game_state_d = GS_PLAY;
          state_d      = S_PLAY;
        end
      end

      default: state_d = S_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PLAY;
      grid_q       <= '0;
      cursor_q     <= START_POS;
      turn_q       <= 1'b0;
      game_state_q <= GS_PLAY;
      win_mask_q   <= '0;
`ifdef MOVE_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grid_q       <= grid_d;
      cursor_q     <= cursor_d;
      turn_q       <= turn_d;
      game_state_q <= game_state_d;
      win_mask_q   <= win_mask_d;
`ifdef MOVE_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign grid_data  = grid_q;
  assign cursor_pos = cursor_q;
  assign turn       = turn_q;
  assign game_state = game_state_q;
  assign win_mask   = win_mask_q;
  assign dbg_state  = state_q;

endmodule
